// File: rtl/trap_pkg.sv
// trap_pkg: shared state type, cause-width helper and reset values for trap_ctrl.
// Defining TRAP_IRQ_EN adds the system IRQ as an extra pending source (index NUM_SRC).
package trap_pkg;
    typedef enum logic [1:0] {IDLE, PENDING, TRAPPED} state_t;
`ifdef TRAP_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif
    localparam state_t RST_STATE = TRAPPED;
    localparam logic   RST_SYNC  = 1'b1;
    function automatic int cause_w(input int num_src);
        int n = IRQ_EN ? num_src + 1 : num_src;
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/trap_prio_enc.sv
// trap_prio_enc: lowest-index-first priority encoder with an any-set flag.
module trap_prio_enc #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         any_o
);
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req_i[i]) idx_o = W'(i);
    end
    assign any_o = |req_i;
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: multi-source trap/NMI controller with queued, acknowledged causes.
// Macro TRAP_IRQ_EN: also trap once per system IRQ assertion (cause = NUM_SRC).
module trap_ctrl import trap_pkg::*; #(
    parameter  int NUM_SRC = 4,
    localparam int CAUSE_W = cause_w(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               m1_n,
    input  logic [NUM_SRC-1:0] trap_req,
    input  logic [NUM_SRC-1:0] trap_mask,
    input  logic               irq_sys_n,
    input  logic               new_isr,
    input  logic               last_isr_jmp,
    input  logic               virtual_enabled,
    input  logic               cause_ack,
    output logic               trap_state,
    output logic               nmi_n,
    output logic               irq_n,
    output logic               capture_address,
    output logic [CAUSE_W-1:0] trap_cause,
    output logic               cause_valid
);
    localparam int P = IRQ_EN ? NUM_SRC + 1 : NUM_SRC;

    state_t             state_q, state_d;
    logic               m1_s1_q, m1_s2_q, m1_h_q, irq_sync_q;
    logic               cap_q, cap_d, valid_q, valid_d;
    logic [CAUSE_W-1:0] cause_q, cause_d, enc_idx;
    logic [P-1:0]       pend_q, pend_d;
    logic               enc_any, m1_fall, m1_rise, ack;

    assign m1_fall = m1_h_q & ~m1_s2_q;
    assign m1_rise = ~m1_h_q & m1_s2_q;
    assign ack     = cause_ack & valid_q;

    trap_prio_enc #(.N(P), .W(CAUSE_W)) u_enc (
        .req_i(pend_q),
        .idx_o(enc_idx),
        .any_o(enc_any)
    );

`ifdef TRAP_IRQ_EN
    logic supp_q, irq_set;
    assign irq_set = ~irq_sync_q & ~supp_q;
`endif

    // Set is applied after the acknowledge clear so a live request wins.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < P; i++)
            if (ack && cause_q == CAUSE_W'(i)) pend_d[i] = 1'b0;
        pend_d[NUM_SRC-1:0] = pend_d[NUM_SRC-1:0] | (trap_req & ~trap_mask);
`ifdef TRAP_IRQ_EN
        pend_d[NUM_SRC] = pend_d[NUM_SRC] | irq_set;
`endif
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        valid_d = valid_q & ~ack;
        cap_d   = cap_q & ~m1_fall;
        case (state_q)
            IDLE:
                if (m1_fall && !virtual_enabled) state_d = TRAPPED;
                else if (enc_any && !valid_q) begin
                    state_d = PENDING;
                    cause_d = enc_idx;
                    valid_d = 1'b1;
                end
            PENDING:
                if (m1_fall && (new_isr || !virtual_enabled)) begin
                    state_d = TRAPPED;
                    cap_d   = new_isr;
                end
            TRAPPED:
                if (m1_fall && last_isr_jmp && virtual_enabled) state_d = IDLE;
            default: state_d = TRAPPED;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q    <= RST_STATE;
            m1_s1_q    <= RST_SYNC;
            m1_s2_q    <= RST_SYNC;
            m1_h_q     <= RST_SYNC;
            irq_sync_q <= 1'b1;
            cap_q      <= 1'b0;
            valid_q    <= 1'b0;
            cause_q    <= '0;
            pend_q     <= '0;
`ifdef TRAP_IRQ_EN
            supp_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            m1_s1_q    <= m1_n;
            m1_s2_q    <= m1_s1_q;
            m1_h_q     <= m1_s2_q;
            irq_sync_q <= m1_rise ? irq_sys_n : irq_sync_q;
            cap_q      <= cap_d;
            valid_q    <= valid_d;
            cause_q    <= cause_d;
            pend_q     <= pend_d;
`ifdef TRAP_IRQ_EN
            // Suppress tracks the asserted IRQ level; it arms in the clk the pend bit sets.
            supp_q     <= ~irq_sync_q;
`endif
        end

    assign trap_state      = (state_q == TRAPPED);
    assign nmi_n           = (state_q != PENDING);
    assign irq_n           = irq_sync_q;
    assign capture_address = cap_q;
    assign trap_cause      = cause_q;
    assign cause_valid     = valid_q;
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: scoreboard bench; the driver plays CPU and hypervisor, the monitor checks each new cause.
module tb_trap_ctrl;
    localparam int N = 4;
`ifdef TRAP_IRQ_EN
    localparam int CW = 3;
`else
    localparam int CW = 2;
`endif
    logic clk = 0, rst = 1, m1_n = 1, irq_sys_n = 1, new_isr = 0, last_isr_jmp = 0;
    logic virtual_enabled = 0, cause_ack = 0;
    logic [N-1:0] trap_req = '0, trap_mask = '0;
    logic trap_state, nmi_n, irq_n, capture_address, cause_valid;
    logic [CW-1:0] trap_cause;
    int tests = 0, fails = 0;
    int exp_q[$];
    logic valid_prev = 0;

    always #5 clk = ~clk;

    trap_ctrl #(.NUM_SRC(N)) dut (
        .clk(clk), .rst(rst), .m1_n(m1_n), .trap_req(trap_req), .trap_mask(trap_mask),
        .irq_sys_n(irq_sys_n), .new_isr(new_isr), .last_isr_jmp(last_isr_jmp),
        .virtual_enabled(virtual_enabled), .cause_ack(cause_ack), .trap_state(trap_state),
        .nmi_n(nmi_n), .irq_n(irq_n), .capture_address(capture_address),
        .trap_cause(trap_cause), .cause_valid(cause_valid)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cause_valid && !valid_prev) begin
            if (exp_q.size() == 0) check("unexpected_cause", int'(trap_cause), -1);
            else check("cause", int'(trap_cause), exp_q.pop_front());
        end
        valid_prev <= cause_valid;
    end

    task automatic m1_cycle(input logic isr, input logic jmp);
        @(negedge clk);
        new_isr = isr; last_isr_jmp = jmp; m1_n = 0;
        repeat (4) @(negedge clk);
        m1_n = 1;
        repeat (4) @(negedge clk);
        new_isr = 0; last_isr_jmp = 0;
    endtask

    task automatic wait_nmi(output bit ok);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = !nmi_n;
        end
    endtask

    task automatic quiet(input string name, input int clks);
        bit stray = 0;
        repeat (clks) begin
            @(negedge clk);
            if (!nmi_n) stray = 1;
        end
        check(name, int'(stray), 0);
    endtask

    task automatic service(input bit first);
        bit ok;
        wait_nmi(ok);
        check("nmi_asserted", int'(ok), 1);
        if (!ok) return;
        m1_cycle(1, 0);
        check("trap_entry", int'(trap_state), 1);
        check("nmi_released", int'(nmi_n), 1);
        if (first) check("capture_set", int'(capture_address), 1);
        @(negedge clk); cause_ack = 1;
        @(negedge clk); cause_ack = 0;
        check("ack_clears_valid", int'(cause_valid), 0);
        m1_cycle(0, 1);
        check("trap_exit", int'(trap_state), 0);
        check("capture_clear", int'(capture_address), 0);
    endtask

    // Reference: pulsed unmasked sources are served in ascending index order, one trap each.
    task automatic txn(input logic [N-1:0] req, input logic [N-1:0] mask);
        int n = 0;
        for (int i = 0; i < N; i++)
            if (req[i] && !mask[i]) begin
                exp_q.push_back(i);
                n++;
            end
        @(negedge clk); trap_req = req; trap_mask = mask;
        @(negedge clk); trap_req = '0; trap_mask = '0;
        for (int k = 0; k < n; k++) service(k == 0);
        quiet("quiet_after_txn", 20);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        bit ok;
        repeat (3) @(negedge clk);
        check("rst_trap_state", int'(trap_state), 1);
        check("rst_nmi_n", int'(nmi_n), 1);
        check("rst_irq_n", int'(irq_n), 1);
        check("rst_capture", int'(capture_address), 0);
        check("rst_cause", int'(trap_cause), 0);
        check("rst_valid", int'(cause_valid), 0);
        rst = 0;
        virtual_enabled = 1;
        m1_cycle(0, 1);
        check("exit_after_reset", int'(trap_state), 0);

        exp_q.push_back(2);
        @(negedge clk); trap_req = 4'b0100;
        @(negedge clk); trap_req = '0;
        check("nmi_lat_1clk", int'(nmi_n), 1);
        @(negedge clk);
        check("nmi_lat_2clk", int'(nmi_n), 0);
        service(1);
        quiet("quiet_after_c2", 20);

        txn(4'b1010, 4'b0000);

        @(negedge clk); trap_mask = 4'b0001; trap_req = 4'b0001;
        quiet("masked_src", 100);
        trap_req = '0; trap_mask = '0;

`ifdef TRAP_IRQ_EN
        irq_sys_n = 0;
        exp_q.push_back(N);
        m1_cycle(0, 0);
        check("irq_n_low", int'(irq_n), 0);
        service(1);
        m1_cycle(0, 0);
        quiet("irq_once", 20);
        irq_sys_n = 1;
        m1_cycle(0, 0);
        check("irq_n_high", int'(irq_n), 1);
        irq_sys_n = 0;
        exp_q.push_back(N);
        m1_cycle(0, 0);
        service(0);
        irq_sys_n = 1;
        m1_cycle(0, 0);
        quiet("irq_rearm_quiet", 20);
`else
        irq_sys_n = 0;
        m1_cycle(0, 0);
        check("irq_n_low", int'(irq_n), 0);
        quiet("irq_no_trap", 20);
        irq_sys_n = 1;
        m1_cycle(0, 0);
        check("irq_n_high", int'(irq_n), 1);
`endif
        check("queue_after_irq", exp_q.size(), 0);

        exp_q.push_back(0);
        @(negedge clk); trap_req = 4'b0001;
        @(negedge clk); trap_req = '0;
        wait_nmi(ok);
        check("pend_before_rst", int'(ok), 1);
        @(negedge clk);
        #2 rst = 1;
        #1;
        check("rst_mid_nmi_n", int'(nmi_n), 1);
        check("rst_mid_trap_state", int'(trap_state), 1);
        check("rst_mid_valid", int'(cause_valid), 0);
        exp_q.delete();
        @(negedge clk); rst = 0;
        m1_cycle(0, 1);
        check("exit_after_rst_mid", int'(trap_state), 0);
        quiet("pend_lost", 20);

        for (int t = 0; t < 30; t++)
            txn(N'($urandom_range(0, 15)), $urandom_range(0, 1) ? N'($urandom_range(0, 15)) : '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Multi-source trap and interrupt controller for the Nabu MegaMapper CPLD; the parametrised successor of the single-source trap/mode logic. It collects NUM_SRC trap requests plus the system IRQ, queues them in sticky pending bits, and raises NMI to the Z80. It enters supervisor (trap) state on the ISR opcode fetch and exposes a priority-encoded cause to the hypervisor, which acknowledges it. The block is fully synchronous to `clk`; the Z80 `m1_n` strobe is sampled rather than used as a clock.

## Interface
- NUM_SRC, 4, number of trap request inputs (1..15)
- CAUSE_W, $clog2(NUM_SRC+1), width of cause code (derived, not overridden)
- clk  in  1  CPLD system clock
- rst  in  1  asynchronous, active-high reset
- m1_n  in  1  Z80 M1, asynchronous; synchronised internally
- trap_req  in  NUM_SRC  level trap requests; bit 0 = highest priority
- trap_mask  in  NUM_SRC  1 = source ignored (not latched)
- irq_sys_n  in  1  system interrupt line, active low
- new_isr  in  1  current fetch is the NMI vector
- last_isr_jmp  in  1  previous trap-mode instruction was a JP
- virtual_enabled  in  1  virtualisation on
- cause_ack  in  1  one-clk pulse: hypervisor consumed trap_cause
- trap_state  out  1  1 = supervisor/trap mode
- nmi_n  out  1  NMI to CPU, active low
- irq_n  out  1  synchronised IRQ to CPU
- capture_address  out  1  high for the first M1 of a trap entry
- trap_cause  out  CAUSE_W  index of the trap being serviced
- cause_valid  out  1  trap_cause holds an unacknowledged cause

## Operation
- m1_n passes through a 2-flop synchroniser plus a history flop. m1_fall/m1_rise are single-clk strobes.
- irq_sync is loaded from irq_sys_n on every m1_rise. irq_n = irq_sync.
- Pending vector pend[NUM_SRC:0]:
  - bit i (i < NUM_SRC) sets each clk while trap_req[i] & !trap_mask[i].
  - bit NUM_SRC is the IRQ source (see Configuration).
  - Set wins over an acknowledge clear in the same clk.
- FSM states: IDLE, PENDING, TRAPPED. trap_state = (state == TRAPPED). nmi_n = !(state == PENDING).
- IDLE:
  - on m1_fall with !virtual_enabled -> TRAPPED, no capture.
  - else if any pend bit is set and !cause_valid -> PENDING. trap_cause <= lowest set index. cause_valid <= 1.
- PENDING:
  - on m1_fall with new_isr -> TRAPPED, capture_address <= 1.
  - on m1_fall with !virtual_enabled -> TRAPPED, no capture.
- TRAPPED:
  - on m1_fall with last_isr_jmp & virtual_enabled -> IDLE.
  - capture_address clears on the next m1_fall after it was set.
- cause_ack while cause_valid: clears pend[trap_cause] and cause_valid. cause_ack with !cause_valid is ignored.
- A new cause is latched only after the previous one is acknowledged. Lower-priority sources wait and are re-raised after the trap exits (queued service).

## Timing
- Reset values: state = TRAPPED (trap_state = 1), nmi_n = 1, irq_n = 1, capture_address = 0, trap_cause = 0, cause_valid = 0, pend = 0, irq suppress = 0, synchroniser = 1.
- m1_n edge-to-strobe latency is 3 clk. clk must be at least 4x the CPU clock.
- trap_req to nmi_n low: 2 clk (pend set, then FSM moves to PENDING).
- nmi_n is held low until the TRAPPED entry clk, then returns high in that same clk as trap_state rises.
- m1_fall coinciding with cause_ack: both take effect; the FSM uses the pre-ack cause_valid.
- rst asserted mid-trap: returns to reset values immediately; queued pend bits are lost.

## Configuration
- TRAP_IRQ_EN defined:
  - pend[NUM_SRC] sets when irq_sync == 0 & !suppress, and suppress <= 1 at the same time.
  - suppress clears when irq_sync == 1. An IRQ therefore traps once per assertion, with cause = NUM_SRC.
- TRAP_IRQ_EN undefined:
  - pend[NUM_SRC] and suppress are removed. IRQ only passes through to irq_n.
  - CAUSE_W = $clog2(NUM_SRC) (minimum 1).

## Structure
- Package trap_pkg: state enum (IDLE, PENDING, TRAPPED), CAUSE_W computation function, reset-value constants.
- Sub-module trap_prio_enc: parameterised lowest-index-first priority encoder. Outputs index and any-set flag.

## Test plan
- Reset with virtual_enabled = 0 -> trap_state = 1, nmi_n = 1. Then virtual_enabled = 1, m1_fall with last_isr_jmp = 1 -> trap_state = 0.
- trap_req = 4'b0100 in IDLE -> nmi_n low 2 clk later. Next m1_fall with new_isr = 1 -> trap_state = 1, capture_address = 1 for one M1, trap_cause = 2, cause_valid = 1.
- trap_req = 4'b1010 together -> cause 1 serviced first. After ack and JP exit -> NMI re-raised with cause 3.
- trap_mask = 4'b0001, trap_req = 4'b0001 -> nmi_n stays 1 for 100 clk.
- TRAP_IRQ_EN with NUM_SRC = 4: irq_sys_n held low across 3 M1 cycles -> exactly one trap with cause 4, irq_n = 0. No second trap until irq_sys_n goes high and low again.
- rst pulse while state = PENDING -> nmi_n = 1, trap_state = 1, cause_valid = 0, pend = 0 in the same clk.
